// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the counter arbiter: FSM state encoding,
// the default counter width and the round-robin pointer increment.
package counter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_CNT_W = 4;

  // Modulo-n increment used to move the round-robin pointer past a winner.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester bus plus the shared counter pins, bundled for the arbiter.
// The slave modport is the arbiter's view; master is the requester/counter side.
interface counter_arbiter_if
  import counter_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_len;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   ctr_reset;
  logic                   ctr_enable;
  logic [CNT_W-1:0]       ctr_value;

  modport master (
    output req, req_len, ctr_value,
    input  grant, done, busy, ctr_reset, ctr_enable
  );

  modport slave (
    input  req, req_len, ctr_value,
    output grant, done, busy, ctr_reset, ctr_enable
  );

endinterface

// File: rtl/counter_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr sits
// at bit 0, take the lowest set bit, then rotate the one-hot result back.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [N_REQ-1:0] req_rot;
  logic [N_REQ-1:0] pick_rot;
  logic             found;

  always_comb begin
    req_rot  = '0;
    pick_rot = '0;
    pick     = '0;
    found    = 1'b0;

    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[PTR_W'((i + int'(rr_ptr)) % N_REQ)];
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (req_rot[i] && !found) begin
        pick_rot[i] = 1'b1;
        found       = 1'b1;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      pick[PTR_W'((i + int'(rr_ptr)) % N_REQ)] = pick_rot[i];
    end

    valid = |req;
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shares one external counter among N_REQ requesters: round-robin grant,
// one-cycle counter clear, req_len cycles of enable, then a done pulse.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic              clk,
  input logic              reset,
  counter_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             busy_q, busy_d;
  logic             ctr_reset_q, ctr_reset_d;
  logic             ctr_enable_q, ctr_enable_d;

  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic [CNT_W-1:0] pick_len;
  logic [PTR_W-1:0] winner_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             owner_live;
  logic             run_last;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_len   = '0;
    winner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_len = bus.req_len[i*CNT_W +: CNT_W];
      if (grant_q[i]) winner_idx = PTR_W'(i);
    end
    next_ptr   = PTR_W'(next_index(int'(winner_idx), N_REQ));
    owner_live = |(grant_q & bus.req);
    // The counter was cleared before RUN, so it reads target-1 on the last enabled cycle.
    run_last   = (bus.ctr_value == (target_q - CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      target_q     <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      ctr_reset_q  <= 1'b0;
      ctr_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      target_q     <= target_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      ctr_reset_q  <= ctr_reset_d;
      ctr_enable_q <= ctr_enable_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = CLEAR;
      end
      CLEAR: begin
        if (!owner_live)          state_d = IDLE;
        else if (target_q == '0)  state_d = DONE;
        else                      state_d = RUN;
      end
      RUN: begin
        if (!owner_live)   state_d = IDLE;
        else if (run_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the transition being taken, so every
  // pin changes on the same edge as the state it belongs to.
  always_comb begin
    grant_d      = grant_q;
    target_d     = target_q;
    rr_ptr_d     = rr_ptr_q;
    done_d       = '0;
    ctr_reset_d  = 1'b0;
    ctr_enable_d = 1'b0;
    busy_d       = (state_d != IDLE);

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d     = pick;
          target_d    = pick_len;
          ctr_reset_d = 1'b1;
        end
      end
      CLEAR, RUN: begin
        if (state_d == IDLE) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else if (state_d == DONE) begin
          done_d = grant_q;
        end else begin
          ctr_enable_d = 1'b1;
        end
      end
      DONE: begin
        grant_d  = '0;
        rr_ptr_d = next_ptr;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.ctr_reset  = ctr_reset_q;
  assign bus.ctr_enable = ctr_enable_q;

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one 4-bit `counter` instance among `N_REQ` requesters. Each requester asks for a count of `req_len` ticks. The block grants requesters round-robin, clears the counter, enables it for exactly `req_len` cycles, and then pulses `done` to the winner. It sits between the requesters and the counter's `reset`/`enable`/`counter` pins, and is the only driver of those pins.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `CNT_W`, default 4: counter width; must match the counter instance.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled only on the rising `clk` edge.
- `req` in `N_REQ`: level request per requester; held high until `done` or until the requester deliberately aborts.
- `req_len` in `N_REQ*CNT_W`: requester i's length in bits [i*CNT_W +: CNT_W]; sampled only at grant.
- `grant` out `N_REQ`: one-hot registered grant; all zero when idle.
- `done` out `N_REQ`: one-cycle one-hot pulse to the granted requester.
- `busy` out 1: high in every state except IDLE.
- `ctr_reset` out 1: drives the counter's active-high synchronous reset.
- `ctr_enable` out 1: drives the counter's enable.
- `ctr_value` in `CNT_W`: the counter's output.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any `req` bit is high, pick a winner with a round-robin scan starting at `rr_ptr`.
  - Register `grant`, latch `target` = winner's `req_len`, assert `ctr_reset`, go to CLEAR.
- CLEAR:
  - `ctr_reset`=1 for exactly one cycle, so the counter is 0 from the next cycle.
  - If `target`==0, go to DONE with `ctr_enable`=0.
  - Otherwise go to RUN with `ctr_enable`=1.
- RUN:
  - The counter increments each cycle.
  - When `ctr_value`==`target`-1, register `ctr_enable`=0 and go to DONE. The counter then holds `target`.
- DONE:
  - `done`=`grant` for one cycle.
  - Next cycle: `grant`=0, `rr_ptr`=(winner+1) mod `N_REQ`, go to IDLE.
- Abort:
  - If the granted `req` bit is low in CLEAR or RUN, next cycle: `ctr_enable`=0, `grant`=0, state=IDLE, no `done`.
  - `rr_ptr` advances past the aborted requester.
- Non-granted `req` changes are ignored until IDLE.
- A requester whose `req` is still high after `done` competes again, but only after every other requester's turn.
- `req_len` may change after grant without effect.
- `target`=2^CNT_W-1 (15) is the maximum. No wrap-around occurs, because `ctr_value` never passes `target`.
- Reset: on any cycle with `reset`=0, at that edge:
  - state=IDLE; `rr_ptr`=0; `target`=0.
  - Outputs `grant`=0, `done`=0, `busy`=0, `ctr_enable`=0, `ctr_reset`=0.
  - A reset mid-RUN abandons the job with no `done`. The counter value is left stale and is cleared at the next grant.

## Timing
- Request seen in IDLE at cycle t:
  - `grant`/`busy`/`ctr_reset` high at t+1.
  - `ctr_enable` high from t+2 to t+1+`target`.
  - `done` at t+2+`target` for any `target`, including 0.
  - `busy` low and a new arbitration possible at t+3+`target`.
- Back-to-back requests: minimum 3+`target` cycles per job; the IDLE cycle is mandatory.
- `ctr_reset` and `ctr_enable` are never high in the same cycle.
- `grant`, `done`, `ctr_*`, `busy` are all registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `counter_arb_pkg`:
  - state enum (IDLE=0, CLEAR=1, RUN=2, DONE=3);
  - `CNT_W` default constant.
- Sub-module `rr_picker`:
  - combinational; inputs `req`, `rr_ptr`; outputs one-hot `pick` and a `valid` flag;
  - built as a rotate, priority-encode, unrotate.
- Top level:
  - FSM, `target` and `rr_ptr` registers;
  - the shared `counter` is instantiated outside the block.

## Test plan
- Reset hold, then `req`=0001, len0=5 → `grant`=0001 at t+1, `ctr_enable` high 5 cycles, `ctr_value`=5 when `done`=0001 at t+7, `busy` low at t+8.
- `req`=1111, all len=1 → grants in order 0001, 0010, 0100, 1000, 0001; each `done` 4 cycles apart.
- len=0 → `ctr_reset` pulse, no `ctr_enable`, `done` at t+2. len=15 → `ctr_value`=15 at `done`, no wrap to 0.
- Drop `req[2]` mid-RUN with len=10 → next cycle `ctr_enable`=0, `grant`=0, no `done`; the next pending requester (index 3) wins.
- `reset`=0 asserted during RUN → all outputs 0 at the next edge. After release, `req`=0110 grants index 1 first.
- Check on every cycle: `ctr_reset` and `ctr_enable` never both high, and `grant` is always one-hot or zero.
